risc5_muldiv: RTL and testbench

Parametrised iterative multiply/divide unit for the RISC5 core family. It replaces the separate fixed 32-bit multiplier and divider with one shared radix-2 datapath. It is generalised in WIDTH, adds floored signed division for any divisor sign, and adds divide-by-zero reporting. It sits beside the ALU and uses the core's run/stall handshake: the core holds run while the instruction is in IR, and it freezes IR/PC while stall is high.

---
 rtl/risc5_muldiv_pkg.sv | 24 ++
 rtl/risc5_muldiv_step.sv | 38 +++
 rtl/risc5_muldiv.sv | 187 ++++++++++++++++++
 tb/tb_risc5_muldiv.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc5_muldiv_pkg.sv
// Shared definitions for the RISC5 iterative multiply/divide unit:
// operation codes, controller states and a two's-complement helper.
package risc5_muldiv_pkg;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   // Widest operand the helper below can handle (WIDTH is limited to 64).
   localparam int MAG_W = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Conditional two's-complement negate; gives |v| when neg flags a negative v.
   // Callers zero-extend a narrower value and keep only their low bits.
   function automatic logic [MAG_W-1:0] cond_neg(input logic [MAG_W-1:0] v,
                                                 input logic             neg);
      return neg ? (~v + MAG_W'(1)) : v;
   endfunction

endpackage

// File: rtl/risc5_muldiv_step.sv
// One radix-2 step of the shared multiply/divide datapath (purely combinational).
// Multiply: a = partial product, b = shifted multiplicand, c = remaining multiplier.
// Divide:   a = {partial remainder, dividend/quotient bits}, b[WIDTH-1:0] = divisor.
module risc5_muldiv_step
   import risc5_muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 op_i,
   input  logic [2*WIDTH-1:0]   a_i,
   input  logic [2*WIDTH-1:0]   b_i,
   input  logic [WIDTH-1:0]     c_i,
   output logic [2*WIDTH-1:0]   a_o,
   output logic [2*WIDTH-1:0]   b_o,
   output logic [WIDTH-1:0]     c_o
);

   logic [WIDTH:0] trial;

   // Add-or-pass for multiply, trial-subtract-and-shift for divide.
   always_comb begin
      // {remainder, next dividend bit} minus divisor; bit WIDTH set means it did not fit.
      trial = a_i[2*WIDTH-1:WIDTH-1] - {1'b0, b_i[WIDTH-1:0]};
      a_o   = a_i;
      b_o   = b_i;
      c_o   = c_i;
      if (op_i == OP_MUL) begin
         a_o = c_i[0] ? (a_i + b_i) : a_i;
         b_o = {b_i[2*WIDTH-2:0], 1'b0};
         c_o = {1'b0, c_i[WIDTH-1:1]};
      end else if (!trial[WIDTH]) begin
         a_o = {trial[WIDTH-1:0], a_i[WIDTH-2:0], 1'b1};
      end else begin
         a_o = {a_i[2*WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/risc5_muldiv.sv
// RISC5 iterative multiply/divide unit with run/stall handshake.
// Signed divide is floored; divide by zero sets dz with lo = all ones, hi = x.
// Optional macro RISC5_MULDIV_EARLY_EN: a multiply finishes as soon as the
// remaining multiplier magnitude is zero (results identical, divide unaffected).
module risc5_muldiv
   import risc5_muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             op,
   input  logic             sgn,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             stall,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi,
   output logic             dz
);

   localparam int CNTW = $clog2(WIDTH + 1);
   localparam int W2   = 2 * WIDTH;

   state_t           state_q, state_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic             op_q, op_d;
   logic             xneg_q, xneg_d;
   logic             yneg_q, yneg_d;
   logic [W2-1:0]    a_q, a_d;
   logic [W2-1:0]    b_q, b_d;
   logic [WIDTH-1:0] c_q, c_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic             dz_q, dz_d;

   logic [WIDTH-1:0] xm, ym;
   logic [W2-1:0]    a_s, b_s;
   logic [WIDTH-1:0] c_s;
   logic             last, early;
   logic [W2-1:0]    prod;
   logic [WIDTH-1:0] qt, rt;
   logic [WIDTH-1:0] fin_lo, fin_hi;
   logic             fin_dz;

   // Operand magnitudes; the sign bits are kept separately for the result fix-up.
   assign xm = WIDTH'(cond_neg(MAG_W'(x), sgn & x[WIDTH-1]));
   assign ym = WIDTH'(cond_neg(MAG_W'(y), sgn & y[WIDTH-1]));

   risc5_muldiv_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .op_i (op_q),
      .a_i  (a_q),
      .b_i  (b_q),
      .c_i  (c_q),
      .a_o  (a_s),
      .b_o  (b_s),
      .c_o  (c_s)
   );

`ifdef RISC5_MULDIV_EARLY_EN
   assign early = (op_q == OP_MUL) && (c_s == '0);
`else
   assign early = 1'b0;
`endif

   assign last  = (cnt_q == CNTW'(WIDTH - 1)) | early;
   assign stall = rst & run & (state_q != DONE);
   assign lo    = lo_q;
   assign hi    = hi_q;
   assign dz    = dz_q;

   // Final result from the last step's output: sign fix-up, floored correction, dz.
   always_comb begin
      prod   = (xneg_q ^ yneg_q) ? (~a_s + W2'(1)) : a_s;
      qt     = WIDTH'(cond_neg(MAG_W'(a_s[WIDTH-1:0]), xneg_q ^ yneg_q));
      rt     = WIDTH'(cond_neg(MAG_W'(a_s[W2-1:WIDTH]), xneg_q));
      fin_lo = qt;
      fin_hi = rt;
      fin_dz = 1'b0;
      if (op_q == OP_MUL) begin
         fin_lo = prod[WIDTH-1:0];
         fin_hi = prod[W2-1:WIDTH];
      end else if (y_q == '0) begin
         fin_lo = '1;
         fin_hi = x_q;
         fin_dz = 1'b1;
      end else if ((a_s[W2-1:WIDTH] != '0) && (xneg_q != yneg_q)) begin
         // Truncated remainder has the wrong sign: step the quotient down one.
         fin_lo = qt - WIDTH'(1);
         fin_hi = rt + y_q;
      end
   end

   // Next-state logic for the IDLE -> BUSY -> DONE sequence and result capture.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      xneg_d  = xneg_q;
      yneg_d  = yneg_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      x_d     = x_q;
      y_d     = y_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      dz_d    = dz_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (run) begin
               op_d    = op;
               xneg_d  = sgn & x[WIDTH-1];
               yneg_d  = sgn & y[WIDTH-1];
               x_d     = x;
               y_d     = y;
               a_d     = (op == OP_DIV) ? {{WIDTH{1'b0}}, xm} : '0;
               b_d     = {{WIDTH{1'b0}}, (op == OP_DIV) ? ym : xm};
               c_d     = ym;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (!run) begin
               // Aborted by the core: drop the operation, keep the old results.
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               a_d = a_s;
               b_d = b_s;
               c_d = c_s;
               if (last) begin
                  state_d = DONE;
                  cnt_d   = '0;
                  lo_d    = fin_lo;
                  hi_d    = fin_hi;
                  dz_d    = fin_dz;
               end else begin
                  cnt_d = cnt_q + CNTW'(1);
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, datapath and result registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= OP_MUL;
         xneg_q  <= 1'b0;
         yneg_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         x_q     <= '0;
         y_q     <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         xneg_q  <= xneg_d;
         yneg_q  <= yneg_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         x_q     <= x_d;
         y_q     <= y_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         dz_q    <= dz_d;
      end
   end

endmodule

// File: tb/tb_risc5_muldiv.sv
// Scoreboard bench for risc5_muldiv: the driver pushes model results, the
// monitor pops and compares whenever the unit reports completion.
module tb_risc5_muldiv;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst, run, op, sgn;
   logic [W-1:0] x, y, lo, hi;
   logic         stall, dz;

   risc5_muldiv #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .run   (run),
      .op    (op),
      .sgn   (sgn),
      .x     (x),
      .y     (y),
      .stall (stall),
      .lo    (lo),
      .hi    (hi),
      .dz    (dz)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic         dz;
      int           lat;   // number of sampled cycles with stall high
   } exp_t;

   exp_t sbq[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   function automatic logic [W-1:0] wv(input longint v);
      return W'(v);
   endfunction

   function automatic logic [W-1:0] minneg();
      logic [W-1:0] m;
      m        = '0;
      m[W-1]   = 1'b1;
      return m;
   endfunction

   // Reference: plain wide-integer arithmetic on the mathematical values.
   function automatic exp_t model(input logic o, input logic s,
                                  input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [127:0] xs, ys, p, q, r;
      logic [127:0]        mag;
      int                  k;
      exp_t                e;
      xs = s ? {{(128-W){a[W-1]}}, a} : {{(128-W){1'b0}}, a};
      ys = s ? {{(128-W){b[W-1]}}, b} : {{(128-W){1'b0}}, b};
      e.dz  = 1'b0;
      e.lat = W + 1;
      if (!o) begin
         p    = xs * ys;
         e.lo = p[W-1:0];
         e.hi = p[2*W-1:W];
`ifdef RISC5_MULDIV_EARLY_EN
         mag = (ys < 0) ? -ys : ys;
         k   = 0;
         for (int i = 0; i < 128; i++) if (mag[i]) k = i + 1;
         e.lat = 1 + ((k < 1) ? 1 : k);
`else
         mag = '0;
         k   = 0;
`endif
      end else if (b == '0) begin
         e.lo = '1;
         e.hi = a;
         e.dz = 1'b1;
      end else begin
         q = xs / ys;
         r = xs % ys;
         if ((r != 0) && ((r < 0) != (ys < 0))) begin
            q = q - 1;
            r = r + ys;
         end
         e.lo = q[W-1:0];
         e.hi = r[W-1:0];
      end
      return e;
   endfunction

   function automatic logic [W-1:0] rnd();
      logic [63:0] r;
      r = {$urandom, $urandom};
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return wv(1);
         2:       return '1;
         3:       return minneg();
         4:       return ~minneg();
         default: return W'(r);
      endcase
   endfunction

   // Start an operation, record its expected result and wait for completion.
   task automatic issue(input logic o, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      int n;
      op  = o;
      sgn = s;
      x   = a;
      y   = b;
      run = 1'b1;
      sbq.push_back(model(o, s, a, b));
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (stall && n < W + 8);
      if (stall) check("done_timeout", 256'(stall), 256'(0));
      @(posedge clk);
      #1;
   endtask

   // Start an operation and withdraw run after k cycles; no result expected.
   task automatic do_abort(input logic o, input logic s, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int k);
      op  = o;
      sgn = s;
      x   = a;
      y   = b;
      run = 1'b1;
      repeat (k) @(posedge clk);
      #1 run = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      run = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: compares at completion, checks outputs hold and reset values otherwise.
   initial begin : monitor
      int           cyc;
      exp_t         e;
      logic [W-1:0] last_lo, last_hi;
      logic         last_dz;
      cyc     = 0;
      last_lo = '0;
      last_hi = '0;
      last_dz = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("reset_stall", 256'(stall), 256'(0));
            check("reset_out", 256'({lo, hi, dz}), 256'(0));
            last_lo = '0;
            last_hi = '0;
            last_dz = 1'b0;
            cyc     = 0;
         end else if (run && !stall) begin
            check("sb_has_entry", 256'(sbq.size() > 0), 256'(1));
            if (sbq.size() > 0) begin
               e = sbq.pop_front();
               check("lo", 256'(lo), 256'(e.lo));
               check("hi", 256'(hi), 256'(e.hi));
               check("dz", 256'(dz), 256'(e.dz));
               check("latency", 256'(cyc), 256'(e.lat));
               last_lo = e.lo;
               last_hi = e.hi;
               last_dz = e.dz;
            end
            cyc = 0;
         end else begin
            check("hold", 256'({lo, hi, dz}), 256'({last_lo, last_hi, last_dz}));
            cyc = run ? cyc + 1 : 0;
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: time limit 1000000 ns reached, required end of test before it");
      $fatal(1);
   end

   initial begin : driver
      rst = 1'b0;
      run = 1'b0;
      op  = 1'b0;
      sgn = 1'b0;
      x   = '0;
      y   = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;

      // Signed multiply, mixed signs.
      issue(1'b0, 1'b1, wv(7), wv(-3));
      idle(2);
      // All-ones operands unsigned then signed, run held between them.
      issue(1'b0, 1'b0, '1, '1);
      issue(1'b0, 1'b1, '1, '1);
      idle(1);
      // Floored signed divides and an unsigned divide, back-to-back.
      issue(1'b1, 1'b1, wv(-7), wv(2));
      issue(1'b1, 1'b1, wv(7), wv(-2));
      issue(1'b1, 1'b0, wv(100), wv(7));
      issue(1'b1, 1'b1, wv(-8), wv(-3));
      idle(1);
      // Divide by zero, then a multiply clears dz; signed divide by zero too.
      issue(1'b1, 1'b0, wv(32'h1234), '0);
      issue(1'b0, 1'b0, wv(3), wv(5));
      issue(1'b1, 1'b1, wv(-5), '0);
      // Most-negative divided by -1 wraps.
      issue(1'b1, 1'b1, minneg(), wv(-1));
      idle(2);
      // Abort mid-divide, then a new multiply the cycle after.
      do_abort(1'b1, 1'b0, wv(1000), wv(3), 5);
      issue(1'b0, 1'b1, wv(-9), wv(11));
      // Small multipliers (shortened latency when early finish is built in).
      issue(1'b0, 1'b1, wv(12345), wv(1));
      issue(1'b0, 1'b1, wv(-77), wv(-1));
      issue(1'b0, 1'b0, wv(42), '0);
      issue(1'b0, 1'b0, wv(42), wv(6));
      idle(1);

      // Asynchronous reset in the middle of a divide.
      op  = 1'b1;
      sgn = 1'b1;
      x   = wv(-1000);
      y   = wv(7);
      run = 1'b1;
      repeat (5) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("async_rst_stall", 256'(stall), 256'(0));
      check("async_rst_out", 256'({lo, hi, dz}), 256'(0));
      run = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      issue(1'b1, 1'b1, wv(-1000), wv(7));
      idle(1);

      // Randomized mix with occasional aborts and back-to-back operations.
      for (int i = 0; i < 70; i++) begin
         logic         o, s;
         logic [W-1:0] a, b;
         o = 1'($urandom_range(0, 1));
         s = 1'($urandom_range(0, 1));
         a = rnd();
         b = rnd();
         if ($urandom_range(0, 9) == 0)
            do_abort(1'b1, s, a, b, int'($urandom_range(1, W - 1)));
         issue(o, s, a, b);
         if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      end

      idle(3);
      check("sb_drained", 256'(sbq.size()), 256'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
